univ_shift_reg: RTL
===================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter: WIDTH, default 8, register length in bits; legal range 2..64.
REQ-002 Parameter: CW, default $clog2(WIDTH+1), width of the shift counter.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: en  input  1  clock enable; 0 means all state holds.
REQ-006 Port: mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 Port: sin  input  1  serial data in.
REQ-008 Port: pin  input  WIDTH  parallel load data.
REQ-009 Port: pout  output  WIDTH  register contents q, registered.
REQ-010 Port: sout  output  1  serial data out.
REQ-011 Port: cnt  output  CW  shifts since last load or reset, saturating at WIDTH.
REQ-012 Port: full  output  1  high when cnt == WIDTH.

Function
REQ-013 Updates occur only on a rising clk edge with en=1 and rst=0; en=0 holds q, cnt and dir regardless of mode.
REQ-014 Mode 00: q, cnt and dir unchanged.
REQ-015 Mode 01, shift right: q <= {sin, q[WIDTH-1:1]}; dir <= 0.
REQ-016 Mode 10, shift left: q <= {q[WIDTH-2:0], sin}; dir <= 1.
REQ-017 Mode 11: q <= pin; cnt <= 0; dir unchanged.
REQ-018 sout is combinational from registered state: q[0] when dir=0, q[WIDTH-1] when dir=1.
REQ-019 Each shift (mode 01 or 10) increments cnt by 1 while cnt < WIDTH; at cnt == WIDTH, cnt holds and the shift still executes.
REQ-020 full = (cnt == WIDTH), combinational from cnt.
REQ-021 Serial latency: in mode 01, the sin value sampled at edge k appears on sout after edge k+WIDTH-1.
REQ-022 Changing direction mid-stream does not clear cnt.
REQ-023 Mode 11 has priority-free semantics: the load fully replaces q, and the sin value that cycle is ignored.
REQ-024 pout equals q at all times and never glitches between edges.

Reset
REQ-025 rst=1 at a rising edge forces q=0, cnt=0, dir=0, so pout=0, sout=0 and full=0 after that edge.
REQ-026 rst overrides en and mode.
REQ-027 rst asserted mid-stream discards all partially shifted data.
REQ-028 The first operation after rst deasserts executes on the next edge with en=1.

Configuration
REQ-029 Macro USR_ROTATE_EN, when defined, adds input port rot (1 bit).
REQ-030 With USR_ROTATE_EN defined and rot=1, mode 01 loads q[0] into the vacated MSB, mode 10 loads q[WIDTH-1] into the vacated LSB, and sin is ignored.
REQ-031 With USR_ROTATE_EN defined and rot=0, or with the macro undefined, shifts are linear and take sin; when undefined, port rot does not exist.
REQ-032 cnt and full behave identically in rotate and linear shifts.

Verification (WIDTH=8)
REQ-033 rst, then en=1, mode=01, sin sequence 1,0,1,1,0,0,1,0 over 8 edges -> pout=8'h4D, cnt=8, full=1; sout = first bit (1) after the 8th edge.
REQ-034 mode=11, pin=8'hA5, then 8 edges of mode=10 with sin=0 -> sout shows 1,0,1,0,0,1,0,1 (MSB first), final pout=8'h00, cnt=8.
REQ-035 pout=8'h3C, en=0 for 5 edges with mode=01 and sin=1 -> pout stays 8'h3C, cnt unchanged.
REQ-036 After 4 shifts (cnt=4), assert rst for 1 edge with en=1, mode=11 -> pout=0, cnt=0, full=0, sout=0.
REQ-037 Saturation: 12 consecutive mode=01 shifts with sin=1 after reset -> cnt=8 from the 8th edge on, full=1, pout=8'hFF.
REQ-038 USR_ROTATE_EN defined: load 8'h81, rot=1, 1 edge of mode=01 -> pout=8'hC0; 1 further edge of mode=10 -> pout=8'h81.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left and parallel load,
// with a saturating shift counter and a direction-dependent serial output.
// Optional feature macro: USR_ROTATE_EN adds input 'rot'. When rot=1, shifts
// recirculate the outgoing bit instead of taking sin.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin,
    input  logic [WIDTH-1:0] pin,
`ifdef USR_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] pout,
    output logic             sout,
    output logic [CW-1:0]    cnt,
    output logic             full
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_LEFT  = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    localparam logic [CW-1:0] CntMax = CW'(WIDTH);

    logic [WIDTH-1:0] qQ, qD;
    logic [CW-1:0]    cntQ, cntD;
    logic             dirQ, dirD;
    logic             fillRight;
    logic             fillLeft;
    logic             cntBump;
    mode_e            modeSel;

    assign modeSel = mode_e'(mode);

    // Pick the bit entering the vacated end: the serial input, or the bit falling off the other end when rotating.
`ifdef USR_ROTATE_EN
    always_comb begin
        fillRight = rot ? qQ[0]       : sin;
        fillLeft  = rot ? qQ[WIDTH-1] : sin;
    end
`else
    always_comb begin
        fillRight = sin;
        fillLeft  = sin;
    end
`endif

    // Next-state for contents, counter and direction; en=0 and hold both leave everything alone.
    always_comb begin
        qD      = qQ;
        cntD    = cntQ;
        dirD    = dirQ;
        cntBump = (cntQ < CntMax);
        if (en) begin
            case (modeSel)
                MODE_RIGHT: begin
                    qD   = {fillRight, qQ[WIDTH-1:1]};
                    dirD = 1'b0;
                    if (cntBump) cntD = cntQ + 1'b1;
                end
                MODE_LEFT: begin
                    qD   = {qQ[WIDTH-2:0], fillLeft};
                    dirD = 1'b1;
                    if (cntBump) cntD = cntQ + 1'b1;
                end
                MODE_LOAD: begin
                    qD   = pin;
                    cntD = '0;
                end
                default: begin
                    qD   = qQ;
                    cntD = cntQ;
                    dirD = dirQ;
                end
            endcase
        end
    end

    // State registers; reset wins over enable and mode and discards any partially shifted data.
    always_ff @(posedge clk) begin
        if (rst) begin
            qQ   <= '0;
            cntQ <= '0;
            dirQ <= 1'b0;
        end else begin
            qQ   <= qD;
            cntQ <= cntD;
            dirQ <= dirD;
        end
    end

    assign pout = qQ;
    assign cnt  = cntQ;
    assign full = (cntQ == CntMax);
    assign sout = dirQ ? qQ[WIDTH-1] : qQ[0];

endmodule
